// File: rtl/axis_frame_source.sv
// Memory-backed AXI-Stream frame source with runtime frame length, frame count and replay addressing.
// Optional read throttling (random bubbles) is enabled with `define AXIS_FRAME_SOURCE_THROTTLE_EN.
module axis_frame_source #(
    parameter int D_W    = 32,
    parameter int DEPTH  = 6144,
    parameter int LEN_W  = 24,
    parameter int CNT_W  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [D_W-1:0]    wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [CNT_W-1:0]  num_frames,
    input  logic              replay,
    output logic [D_W-1:0]    m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  frame_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  nfr_q, nfr_d;
    logic              replay_q, replay_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]  fr_issued_q, fr_issued_d;
    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              done_q, done_d;

    logic [D_W-1:0]    mem [DEPTH];
    logic [D_W-1:0]    buf_data_q [2];
    logic              buf_last_q [2];

    logic              throttle_ok;
    logic              issue;
    logic              pop;
    logic              last_beat;
    logic              last_read;
    logic [ADDR_W-1:0] next_addr;

`ifdef AXIS_FRAME_SOURCE_THROTTLE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1; bit 0 gates read issue
    always_comb begin
        lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        throttle_ok = lfsr_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign throttle_ok = 1'b1;
`endif

    assign m_tvalid  = (count_q != 2'd0);
    assign m_tdata   = buf_data_q[rd_ptr_q];
    assign m_tlast   = m_tvalid & buf_last_q[rd_ptr_q];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

    assign pop       = m_tvalid & m_tready;
    assign issue     = (state_q == RUN) && (count_q < 2'd2) && throttle_ok;
    assign last_beat = (beat_q == len_q - LEN_W'(1));
    assign last_read = last_beat && (fr_issued_q == nfr_q - CNT_W'(1));
    assign next_addr = (rd_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : rd_addr_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        nfr_d       = nfr_q;
        replay_d    = replay_q;
        rd_addr_d   = rd_addr_q;
        beat_d      = beat_q;
        fr_issued_d = fr_issued_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;

        if (issue) wr_ptr_d = ~wr_ptr_q;
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            if (m_tlast) frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
        if (issue && !pop)      count_d = count_q + 2'd1;
        else if (!issue && pop) count_d = count_q - 2'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    len_d       = frame_len;
                    nfr_d       = num_frames;
                    replay_d    = replay;
                    frame_cnt_d = '0;
                    if (frame_len != '0 && num_frames != '0) begin
                        state_d     = RUN;
                        rd_addr_d   = base_addr;
                        beat_d      = '0;
                        fr_issued_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    if (last_beat) begin
                        beat_d      = '0;
                        fr_issued_d = fr_issued_q + CNT_W'(1);
                        rd_addr_d   = replay_q ? base_q : next_addr;
                    end else begin
                        beat_d    = beat_q + LEN_W'(1);
                        rd_addr_d = next_addr;
                    end
                    if (last_read) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // No reads remain, so the pop that empties the buffer is the final beat
                if (pop && count_q == 2'd1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            nfr_q       <= '0;
            replay_q    <= 1'b0;
            rd_addr_q   <= '0;
            beat_q      <= '0;
            fr_issued_q <= '0;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            nfr_q       <= nfr_d;
            replay_q    <= replay_d;
            rd_addr_q   <= rd_addr_d;
            beat_q      <= beat_d;
            fr_issued_q <= fr_issued_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // The synchronous read port lands directly in a prefetch entry, giving one cycle of latency
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q[0] <= 1'b0;
            buf_last_q[1] <= 1'b0;
        end else if (issue) begin
            buf_data_q[wr_ptr_q] <= mem[rd_addr_q];
            buf_last_q[wr_ptr_q] <= last_beat;
        end
    end

endmodule

// File: tb/tb_axis_frame_source.sv
// Directed self-checking bench for axis_frame_source (DEPTH=16 instance).
module tb_axis_frame_source;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic [3:0]  base_addr;
    logic [23:0] frame_len;
    logic [7:0]  num_frames;
    logic        replay;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        busy;
    logic        done;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int fails  = 0;

    logic [31:0] got_data[$];
    logic        got_last[$];
    int          done_cnt;
    int          gaps;
    int          stall_viol;
    int          first_valid;
    bit          timed_out;

    axis_frame_source #(
        .D_W(32), .DEPTH(16), .LEN_W(24), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .base_addr(base_addr), .frame_len(frame_len),
        .num_frames(num_frames), .replay(replay),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] mem_val(input int addr);
        return 32'h0000_1000 + 32'(addr % 16);
    endfunction

    task automatic do_start(input logic [3:0] b, input logic [23:0] l, input logic [7:0] n, input logic r);
        base_addr  = b;
        frame_len  = l;
        num_frames = n;
        replay     = r;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = ~b;
        frame_len  = 24'd1;
        num_frames = 8'd0;
        replay     = ~r;
    endtask

    task automatic collect(input bit toggle, input int max_cycles);
        int          c = 0;
        int          tail = 0;
        bit          seen = 0;
        bit          stalled = 0;
        logic [31:0] pd = '0;
        logic        pl = 1'b0;
        got_data.delete();
        got_last.delete();
        done_cnt = 0; gaps = 0; stall_viol = 0; first_valid = -1; timed_out = 0;
        forever begin
            m_tready = toggle ? ((c % 3 == 0) ? 1'b1 : 1'b0) : 1'b1;
            if (stalled && (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl)) stall_viol++;
            if (m_tvalid === 1'b1 && first_valid < 0) first_valid = c;
            if (m_tvalid !== 1'b1 && busy === 1'b1 && got_data.size() > 0) gaps++;
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                got_data.push_back(m_tdata);
                got_last.push_back(m_tlast);
            end
            if (done === 1'b1) done_cnt++;
            stalled = (m_tvalid === 1'b1) && (m_tready === 1'b0);
            pd = m_tdata;
            pl = m_tlast;
            if (seen) tail++;
            else if (done === 1'b1 && busy === 1'b0) seen = 1;
            if (tail >= 3) break;
            c++;
            if (c >= max_cycles) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
        end
        m_tready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        base_addr = '0; frame_len = '0; num_frames = '0; replay = 1'b0; m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (m_tvalid !== 1'b0) begin fails++; $display("[TB] FAIL reset_tvalid: got %b expected 0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin fails++; $display("[TB] FAIL reset_tlast: got %b expected 0", m_tlast); end
        checks++; if (m_tdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_tdata: got %h expected 0", m_tdata); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (frame_cnt !== 8'd0) begin fails++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = mem_val(i);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_contiguous();
        logic [31:0] exp_d[6];
        logic        exp_l[6];
        for (int i = 0; i < 6; i++) begin
            exp_d[i] = mem_val(4 + i);
            exp_l[i] = (i == 2 || i == 5);
        end
        do_start(4'd4, 24'd3, 8'd2, 1'b0);
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL contig_busy_after_start: got %b expected 1", busy); end
        checks++; if (m_tvalid !== 1'b0) begin fails++; $display("[TB] FAIL contig_no_early_valid: got %b expected 0", m_tvalid); end
        collect(1'b0, 200);
        checks++; if (timed_out) begin fails++; $display("[TB] FAIL contig_timeout: got timeout expected done"); end
`ifndef AXIS_FRAME_SOURCE_THROTTLE_EN
        checks++; if (first_valid !== 1) begin fails++; $display("[TB] FAIL contig_first_valid_cycle: got %0d expected 1", first_valid); end
        checks++; if (gaps !== 0) begin fails++; $display("[TB] FAIL contig_gaps: got %0d expected 0", gaps); end
`endif
        checks++; if (got_data.size() !== 6) begin fails++; $display("[TB] FAIL contig_beat_count: got %0d expected 6", got_data.size()); end
        for (int i = 0; i < 6 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp_d[i]) begin fails++; $display("[TB] FAIL contig_data[%0d]: got %h expected %h", i, got_data[i], exp_d[i]); end
            checks++; if (got_last[i] !== exp_l[i]) begin fails++; $display("[TB] FAIL contig_last[%0d]: got %b expected %b", i, got_last[i], exp_l[i]); end
        end
        checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL contig_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (frame_cnt !== 8'd2) begin fails++; $display("[TB] FAIL contig_frame_cnt: got %0d expected 2", frame_cnt); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL contig_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_replay();
        logic [31:0] exp_d[6];
        logic        exp_l[6];
        for (int i = 0; i < 6; i++) begin
            exp_d[i] = mem_val(4 + (i % 3));
            exp_l[i] = (i % 3 == 2);
        end
        do_start(4'd4, 24'd3, 8'd2, 1'b1);
        collect(1'b0, 200);
        checks++; if (timed_out) begin fails++; $display("[TB] FAIL replay_timeout: got timeout expected done"); end
        checks++; if (got_data.size() !== 6) begin fails++; $display("[TB] FAIL replay_beat_count: got %0d expected 6", got_data.size()); end
        for (int i = 0; i < 6 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp_d[i]) begin fails++; $display("[TB] FAIL replay_data[%0d]: got %h expected %h", i, got_data[i], exp_d[i]); end
            checks++; if (got_last[i] !== exp_l[i]) begin fails++; $display("[TB] FAIL replay_last[%0d]: got %b expected %b", i, got_last[i], exp_l[i]); end
        end
        checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL replay_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (frame_cnt !== 8'd2) begin fails++; $display("[TB] FAIL replay_frame_cnt: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_backpressure();
        do_start(4'd0, 24'd4, 8'd1, 1'b0);
        collect(1'b1, 300);
        checks++; if (timed_out) begin fails++; $display("[TB] FAIL bp_timeout: got timeout expected done"); end
        checks++; if (stall_viol !== 0) begin fails++; $display("[TB] FAIL bp_stall_stability: got %0d violations expected 0", stall_viol); end
        checks++; if (got_data.size() !== 4) begin fails++; $display("[TB] FAIL bp_beat_count: got %0d expected 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== mem_val(i)) begin fails++; $display("[TB] FAIL bp_data[%0d]: got %h expected %h", i, got_data[i], mem_val(i)); end
            checks++; if (got_last[i] !== (i == 3)) begin fails++; $display("[TB] FAIL bp_last[%0d]: got %b expected %b", i, got_last[i], (i == 3)); end
        end
        checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL bp_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_wrap();
        int exp_a[4] = '{14, 15, 0, 1};
        do_start(4'd14, 24'd4, 8'd1, 1'b0);
        collect(1'b0, 200);
        checks++; if (timed_out) begin fails++; $display("[TB] FAIL wrap_timeout: got timeout expected done"); end
        checks++; if (got_data.size() !== 4) begin fails++; $display("[TB] FAIL wrap_beat_count: got %0d expected 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== mem_val(exp_a[i])) begin fails++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", i, got_data[i], mem_val(exp_a[i])); end
        end
        checks++; if (frame_cnt !== 8'd1) begin fails++; $display("[TB] FAIL wrap_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_degenerate();
        int vcount = 0;
        int dcount = 0;
        m_tready = 1'b1;
        do_start(4'd2, 24'd3, 8'd0, 1'b0);
        checks++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL degen_nf0_done: got %b expected 1", done); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL degen_nf0_busy: got %b expected 0", busy); end
        checks++; if (frame_cnt !== 8'd0) begin fails++; $display("[TB] FAIL degen_frame_cnt_clear: got %0d expected 0", frame_cnt); end
        repeat (5) begin
            @(posedge clk); #1;
            if (m_tvalid !== 1'b0) vcount++;
            if (done !== 1'b0) dcount++;
        end
        checks++; if (vcount !== 0) begin fails++; $display("[TB] FAIL degen_nf0_no_valid: got %0d valid cycles expected 0", vcount); end
        checks++; if (dcount !== 0) begin fails++; $display("[TB] FAIL degen_nf0_single_done: got %0d extra done cycles expected 0", dcount); end
        do_start(4'd2, 24'd0, 8'd3, 1'b0);
        checks++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL degen_len0_done: got %b expected 1", done); end
        checks++; if (m_tvalid !== 1'b0) begin fails++; $display("[TB] FAIL degen_len0_valid: got %b expected 0", m_tvalid); end
        m_tready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_restart_ignored();
        m_tready = 1'b0;
        do_start(4'd0, 24'd4, 8'd1, 1'b0);
        base_addr = 4'd8; frame_len = 24'd2; num_frames = 8'd3; replay = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL restart_busy: got %b expected 1", busy); end
        collect(1'b0, 200);
        checks++; if (timed_out) begin fails++; $display("[TB] FAIL restart_timeout: got timeout expected done"); end
        checks++; if (got_data.size() !== 4) begin fails++; $display("[TB] FAIL restart_beat_count: got %0d expected 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== mem_val(i)) begin fails++; $display("[TB] FAIL restart_data[%0d]: got %h expected %h", i, got_data[i], mem_val(i)); end
        end
        checks++; if (frame_cnt !== 8'd1) begin fails++; $display("[TB] FAIL restart_frame_cnt: got %0d expected 1", frame_cnt); end
        checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL restart_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_abort();
        int vcount = 0;
        int dcount = 0;
        m_tready = 1'b1;
        do_start(4'd0, 24'd8, 8'd2, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
            if (done !== 1'b0) dcount++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (m_tvalid !== 1'b0) begin fails++; $display("[TB] FAIL abort_tvalid: got %b expected 0", m_tvalid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (frame_cnt !== 8'd0) begin fails++; $display("[TB] FAIL abort_frame_cnt: got %0d expected 0", frame_cnt); end
        if (done !== 1'b0) dcount++;
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (m_tvalid !== 1'b0) vcount++;
            if (done !== 1'b0) dcount++;
        end
        checks++; if (vcount !== 0) begin fails++; $display("[TB] FAIL abort_no_valid: got %0d valid cycles expected 0", vcount); end
        checks++; if (dcount !== 0) begin fails++; $display("[TB] FAIL abort_no_done: got %0d done cycles expected 0", dcount); end
    endtask

    task automatic test_throttle_long();
        int bad_d = 0;
        int bad_l = 0;
        do_start(4'd0, 24'd64, 8'd2, 1'b0);
        collect(1'b0, 3000);
        checks++; if (timed_out) begin fails++; $display("[TB] FAIL long_timeout: got timeout expected done"); end
        checks++; if (got_data.size() !== 128) begin fails++; $display("[TB] FAIL long_beat_count: got %0d expected 128", got_data.size()); end
        for (int i = 0; i < 128 && i < got_data.size(); i++) begin
            if (got_data[i] !== mem_val(i)) bad_d++;
            if (got_last[i] !== (i == 63 || i == 127)) bad_l++;
        end
        checks++; if (bad_d !== 0) begin fails++; $display("[TB] FAIL long_data_order: got %0d wrong beats expected 0", bad_d); end
        checks++; if (bad_l !== 0) begin fails++; $display("[TB] FAIL long_tlast: got %0d wrong tlast flags expected 0", bad_l); end
        checks++; if (frame_cnt !== 8'd2) begin fails++; $display("[TB] FAIL long_frame_cnt: got %0d expected 2", frame_cnt); end
        checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL long_done_pulses: got %0d expected 1", done_cnt); end
`ifdef AXIS_FRAME_SOURCE_THROTTLE_EN
        checks++; if (!(gaps > 0)) begin fails++; $display("[TB] FAIL long_throttle_gaps: got %0d expected >0", gaps); end
`else
        checks++; if (gaps !== 0) begin fails++; $display("[TB] FAIL long_gaps: got %0d expected 0", gaps); end
`endif
    endtask

    // Scenarios run back to back on one instance; memory contents persist across them
    initial begin
        test_reset();
        test_contiguous();
        test_replay();
        test_backpressure();
        test_wrap();
        test_degenerate();
        test_restart_ignored();
        test_abort();
        test_throttle_long();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/axis_frame_source.md
Name: axis_frame_source

Overview:
- Synthesizable, parametrised successor to the hand-written per-operand stimulus loops used around `mm_gelu` (A, W, W_bias, out_m, out_e).
- A memory-backed AXI-Stream master: replays framed data (matrix tiles, biases, requant constants) into accelerator stream inputs.
- Adds behaviour the bench loops lack: runtime frame length, frame count, replay/continue addressing, a stall-safe prefetch buffer and start/done control.
- Used both in hardware self-test wrappers and benches.

Parameters:
- D_W, 32, stream data width (bits).
- DEPTH, 6144, memory words; ADDR_W = $clog2(DEPTH).
- LEN_W, 24, width of frame_len.
- CNT_W, 8, width of num_frames and frame_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- wr_en  in  1  memory write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  D_W  write data.
- start  in  1  pulse; launch a transfer using the config inputs.
- base_addr  in  ADDR_W  first word of frame 0.
- frame_len  in  LEN_W  beats per frame.
- num_frames  in  CNT_W  frames to send.
- replay  in  1  1: every frame restarts at base_addr; 0: frames are contiguous.
- m_tdata  out  D_W  stream data.
- m_tvalid  out  1  stream valid.
- m_tlast  out  1  last beat of each frame.
- m_tready  in  1  stream ready.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the final beat is accepted.
- frame_cnt  out  CNT_W  frames fully accepted in the current transfer.

Behaviour:
- Reset is synchronous, active-high on rst; clock is clk. Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0, frame_cnt=0; FSM=IDLE; prefetch buffer empty.
- Memory is single-port-write, synchronous-read, 1-cycle read latency.
  - Read-during-write to the same address returns the old data.
  - Writes are accepted in any state.
- Config latch:
  - On start in IDLE, base_addr, frame_len, num_frames and replay are latched. Config inputs are don't-care afterwards.
  - start while busy is ignored.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start when frame_len!=0 and num_frames!=0; busy=1 from the next cycle.
  - If frame_len==0 or num_frames==0: no beats are sent, done pulses the cycle after start, and the FSM stays in IDLE.
  - RUN: issue one read per cycle while (buffer occupancy + reads in flight) < 2.
  - Read address starts at base_addr and increments by 1, wrapping DEPTH-1 -> 0.
  - After the last beat of a frame: address goes back to base_addr if replay=1, otherwise it continues.
  - RUN -> DRAIN when the final read (num_frames*frame_len total) is issued.
  - DRAIN -> IDLE when the final beat handshakes. done=1 that same cycle (registered, visible next cycle); busy=0 next cycle.
- Output buffer: a 2-entry skid/prefetch buffer.
  - m_tdata, m_tvalid and m_tlast are driven from the head entry.
  - While m_tvalid=1 and m_tready=0, tdata and tlast are held stable.
  - With m_tready held at 1, throughput is 1 beat/cycle after the first beat.
  - The first m_tvalid rises 2 cycles after start (read issued at cycle 1, data at cycle 2).
- m_tlast is tagged at read-issue time on the beat with index frame_len-1 within its frame.
- frame_cnt increments on every handshake with m_tlast=1, and clears on an accepted start.
- Beat counter is LEN_W wide; frame counter is CNT_W wide. No arithmetic overflow is possible because both counts are bounded by the latched config.
- Reset mid-transfer: everything is aborted at once, the buffer is flushed, m_tvalid=0 the next cycle, and done is not pulsed.

Optional Feature:
- Macro AXIS_FRAME_SOURCE_THROTTLE_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) gates read issue.
  - Reads are issued only in cycles where lfsr[0]=1, which inserts random bubbles into m_tvalid for downstream stress testing.
  - Data order, tlast positions and done semantics are unchanged.
- Undefined: no LFSR logic; reads are issued whenever buffer space allows.

Test Plan:
- Write mem[i]=i for i=0..15; start with base_addr=4, frame_len=3, num_frames=2, replay=0, m_tready=1 -> beats 4,5,6,7,8,9; tlast on 6 and 9; done pulses once; frame_cnt=2; busy low afterwards.
- Same as above with replay=1 -> beats 4,5,6,4,5,6; tlast on each 6.
- Backpressure: frame_len=4, base_addr=0; m_tready toggles 1,0,0,1,... -> tdata and tlast stable while stalled; sequence 0,1,2,3 exact with no duplicates or drops.
- Wrap: DEPTH=16 instance, base_addr=14, frame_len=4 -> beats mem[14], mem[15], mem[0], mem[1].
- Degenerate and abort:
  - num_frames=0 -> no m_tvalid, done the cycle after start.
  - A second start during busy is ignored.
  - rst asserted mid-frame -> m_tvalid=0 next cycle, no done.
- Throttle build (AXIS_FRAME_SOURCE_THROTTLE_EN), m_tready=1, frame_len=64, num_frames=2 -> same 128-beat sequence as the unthrottled run, with some m_tvalid=0 gaps present.
